// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, fixed-latency imem reads and a small {pc, word} FIFO toward decode.
// Optional FETCH_BYPASS_EN forwards a returning word straight to decode when the FIFO is empty.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    logic [31:0]   pc_r;
    logic [31:0]   inflight_pc_r;
    logic          inflight_r;
    logic [31:0]   fifo_pc_r   [DEPTH];
    logic [31:0]   fifo_word_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW:0]   count_r;

    logic          credit_s;
    logic          req_s;
    logic          fifo_nonempty_s;
    logic          bypass_s;
    logic          valid_s;
    logic          push_s;
    logic          pop_s;

    // Request issue: only when every buffered plus in-flight word still has a FIFO slot.
    always_comb begin
        credit_s  = (({1'b0, count_r}) + (AW+2)'(inflight_r)) < DEPTH_W;
        req_s     = !rst && !redirect_valid && credit_s;
        imem_req  = req_s;
        if (req_s) begin
            imem_addr = pc_r;
        end else begin
            imem_addr = 32'h0000_0000;
        end
    end

    // Decode-side presentation plus push/pop decisions.
    always_comb begin
        fifo_nonempty_s = (count_r != {(AW+1){1'b0}});
`ifdef FETCH_BYPASS_EN
        bypass_s = !rst && !fifo_nonempty_s && inflight_r && !redirect_valid;
`else
        bypass_s = 1'b0;
`endif
        valid_s     = !rst && (fifo_nonempty_s || bypass_s);
        instr_valid = valid_s;
        instruction = 32'h0000_0000;
        instr_pc    = 32'h0000_0000;
        if (!valid_s) begin
            instruction = 32'h0000_0000;
            instr_pc    = 32'h0000_0000;
        end else if (fifo_nonempty_s) begin
            instruction = fifo_word_r[rd_ptr_r];
            instr_pc    = fifo_pc_r[rd_ptr_r];
        end else begin
            instruction = imem_rdata;
            instr_pc    = inflight_pc_r;
        end
        pop_s  = !rst && fifo_nonempty_s && instr_ready;
        // A bypassed word that the decoder takes this cycle never enters the FIFO.
        push_s = inflight_r && !redirect_valid && !(bypass_s && instr_ready);
    end

    // PC, in-flight tracking and FIFO state; redirect flushes everything, reset overrides all.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
            rd_ptr_r      <= {AW{1'b0}};
            wr_ptr_r      <= {AW{1'b0}};
            count_r       <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_r[i]   <= 32'h0000_0000;
                fifo_word_r[i] <= 32'h0000_0000;
            end
        end else if (redirect_valid) begin
            pc_r       <= redirect_pc & 32'hFFFF_FFFC;
            inflight_r <= 1'b0;
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
        end else begin
            if (req_s) begin
                pc_r          <= pc_r + 32'd4;
                inflight_pc_r <= pc_r;
                inflight_r    <= 1'b1;
            end else begin
                inflight_r <= 1'b0;
            end
            if (push_s) begin
                fifo_pc_r[wr_ptr_r]   <= inflight_pc_r;
                fifo_word_r[wr_ptr_r] <= imem_rdata;
                wr_ptr_r              <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the control unit. Holds the program counter, issues word reads to a fixed-latency instruction memory, and buffers returned words with their PCs in a small FIFO. Presents one instruction at a time to the decoder over a valid/ready handshake. Accepts a redirect (branch/jump target) that flushes all buffered and in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 4: FIFO entries; power of two, ≥2.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  read request this cycle
- imem_addr  out  32  word-aligned read address; valid when imem_req
- imem_rdata  in  32  read data, valid exactly one cycle after imem_req; memory never stalls
- redirect_valid  in  1  load new PC and flush
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced 0)
- instr_valid  out  1  instruction/instr_pc hold a fetched word
- instr_ready  in  1  decoder accepts the head entry
- instruction  out  32  fetched instruction word (control unit `instruction` input)
- instr_pc  out  32  address of `instruction`

## Operation
- State: pc[31:0], FIFO of {pc, word} with count 0..DEPTH, inflight flag (1 = request issued last cycle), inflight_pc.
- Issue: imem_req = !rst && !redirect_valid && (count + inflight < DEPTH). On issue: imem_addr = pc, inflight_pc <= pc, pc <= pc + 4 (mod 2^32, wraps FFFF_FFFC -> 0000_0000), inflight <= 1; otherwise inflight <= 0.
- Response: when inflight = 1 and no redirect this cycle, {inflight_pc, imem_rdata} is pushed. Credit rule guarantees a push never finds FIFO full.
- Pop: instr_valid && instr_ready removes head. Push and pop in the same cycle leave count unchanged.
- Order: instructions delivered strictly in PC order between redirects; no duplicates, no gaps.
- Redirect (redirect_valid = 1): pc <= {redirect_pc[31:2], 2'b00}; FIFO count <= 0; inflight <= 0 (response arriving this cycle is discarded); no request this cycle. A pop handshaking in the same cycle is still valid (decoder consumed it); everything else is lost.
- Outputs when instr_valid = 0: instruction = 0, instr_pc = 0.
- Back-to-back redirects: each reloads PC; last one wins; no request until the cycle after the final redirect.

## Timing
- Reset (rst high at a clock edge): pc = RESET_PC, count = 0, inflight = 0; combinationally imem_req = 0, imem_addr = 0 while rst high, instr_valid = 0, instruction = 0, instr_pc = 0.
- Cycle 0 = first cycle rst low: imem_req = 1, imem_addr = RESET_PC.
- Request in cycle N -> data on imem_rdata in N+1 -> written to FIFO at end of N+1 -> instr_valid in N+2 (fetch-to-decode latency 2).
- Redirect in cycle R: instr_valid = 0 in R+1; request to redirect target in R+1; instruction visible in R+3.
- Steady state with instr_ready held high: one instruction per cycle, no bubbles.
- instr_ready low: at most DEPTH requests outstanding+buffered; instr_valid, instruction, instr_pc stable until handshake.
- rst mid-operation overrides redirect and all activity; state returns to reset values on that edge.

## Configuration
- FETCH_BYPASS_EN defined: when FIFO is empty and inflight = 1 (no redirect), instruction/instr_pc/instr_valid are driven directly from imem_rdata/inflight_pc; if instr_ready is high that cycle the word is consumed and not pushed, otherwise it is pushed. Fetch-to-decode latency 1; redirect-to-valid latency 2. Credit rule unchanged.
- Not defined: all responses go through the FIFO; latencies as in Timing.

## Test plan
- Reset with RESET_PC = 0, memory returns word = address, instr_ready = 1 -> instr_valid first in cycle 2 (cycle 1 with FETCH_BYPASS_EN); instr_pc 0x0, 0x4, 0x8, … one per cycle, instruction == instr_pc.
- instr_ready = 0 from reset -> exactly 4 requests (0x0, 0x4, 0x8, 0xC) then imem_req = 0; head holds pc 0x0; raise instr_ready -> 0x0..0xC drain in order, requests resume at 0x10 with no gap in delivered PCs.
- Redirect to 0x0000_0103 while a request is in flight and FIFO holds 2 entries -> instr_valid 0 next cycle; next delivered instr_pc = 0x100, then 0x104; no stale PC ever delivered.
- Redirect coincident with a pop handshake at pc 0x8 -> pop counts (decoder saw 0x8), next delivered pc is redirect target.
- RESET_PC = 0xFFFF_FFF8 -> delivered PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- rst asserted for one cycle mid-stream with FIFO at 3 entries -> next cycle instr_valid = 0, then sequence restarts from RESET_PC with cycle-2 latency.
